// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - multi-cycle multiply/divide unit with HI/LO registers
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   ca, cb;
  logic [1:0]    cop;
  logic          md_go, mt_go, done;
  logic [63:0]   res;

  logic signed [63:0] mul_s;
  logic        [63:0] mul_u;
  logic signed [31:0] sq, sr;

  // md ops are ops 0..3 (op[2] clear); MTHI/MTLO are 4 and 5; 6/7 fall through as no-ops
  assign md_go     = (state == IDLE) && start && !op[2];
  assign mt_go     = (state == IDLE) && start && (op == 3'd4 || op == 3'd5);
  assign done      = (state == RUN) && (cnt == CW'(1));
  assign busy      = (state == RUN);
  assign stall_req = busy | (start & ~op[2]);

  // Arithmetic works only on the captured operands so E-stage operand changes during RUN are harmless
  assign mul_s = $signed({{32{ca[31]}}, ca}) * $signed({{32{cb[31]}}, cb});
  assign mul_u = {32'd0, ca} * {32'd0, cb};
  assign sq    = $signed(ca) / $signed(cb);
  assign sr    = $signed(ca) % $signed(cb);

  // Select the pending {hi,lo} result, covering divide-by-zero and the signed overflow case explicitly
  always_comb begin
    res = 64'd0;
    case (cop)
      2'd0: res = mul_s;
      2'd1: res = mul_u;
      2'd2: begin
        if (cb == 32'd0)
          res = {ca, 32'hFFFF_FFFF};
        else if (ca == 32'h8000_0000 && cb == 32'hFFFF_FFFF)
          res = {32'd0, 32'h8000_0000};
        else
          res = {sr, sq};
      end
      default: begin
        if (cb == 32'd0)
          res = {ca, 32'hFFFF_FFFF};
        else
          res = {ca % cb, ca / cb};
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: IDLE -> RUN on an accepted md op, RUN -> IDLE on the final count
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (md_go) state_nxt = RUN;
      RUN:     if (done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latency counter and operand capture; counter loads N so busy covers exactly N edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      ca  <= '0;
      cb  <= '0;
      cop <= '0;
    end else if (md_go) begin
      cnt <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      ca  <= a;
      cb  <= b;
      cop <= op[1:0];
    end else if (state == RUN) begin
      cnt <= cnt - CW'(1);
    end
  end

  // HI/LO update: result on completion, or direct move from rs in IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (done) begin
      hi <= res[63:32];
      lo <= res[31:0];
    end else if (mt_go) begin
      if (op == 3'd4) hi <= a;
      else            lo <= a;
    end
  end

endmodule
